sine_wave: RTL and testbench

SINE_WAVE -- requirements
Module: sine_wave

---
 rtl/sine_wave_pkg.sv | 53 +++++
 rtl/sine_wave_cordic_stage.sv | 52 +++++
 rtl/sine_wave.sv | 140 ++++++++++++++
 tb/tb_sine_wave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sine_wave_pkg.sv
// Shared constants for the CORDIC sine/cosine generator.
//   - CORDIC_GAIN    : 0.607253 * 2^16, pre-scales the start vector so the
//                      rotation gain cancels and the result peaks at ampl
//   - XY_FRAC_BITS   : fractional bits carried in the x/y datapath
//   - quadrant_t     : quarter-turn selected by the top two phase bits
//   - atan_turn()    : atan(2^-i) for i = 0..23 as a 32-bit fraction of a turn
package sine_wave_pkg;

   localparam int unsigned CORDIC_GAIN      = 39797;
   localparam int          CORDIC_GAIN_BITS = 16;

   // One fractional bit halves the truncation error of the shift terms and
   // still leaves headroom: |x|,|y| never exceed 2*ampl < 2^(DATA_WIDTH+1).
   localparam int          XY_FRAC_BITS     = 1;

   typedef enum logic [1:0] {
      QUAD_0   = 2'd0,
      QUAD_90  = 2'd1,
      QUAD_180 = 2'd2,
      QUAD_270 = 2'd3
   } quadrant_t;

   function automatic logic [31:0] atan_turn(input int iter);
      case (iter)
         0:       return 32'h2000_0000;
         1:       return 32'h12E4_051D;
         2:       return 32'h09FB_385B;
         3:       return 32'h0511_11D4;
         4:       return 32'h028B_0D43;
         5:       return 32'h0145_D7E1;
         6:       return 32'h00A2_F61E;
         7:       return 32'h0051_7C55;
         8:       return 32'h0028_BE53;
         9:       return 32'h0014_5F2E;
         10:      return 32'h000A_2F98;
         11:      return 32'h0005_17CC;
         12:      return 32'h0002_8BE6;
         13:      return 32'h0001_45F3;
         14:      return 32'h0000_A2F9;
         15:      return 32'h0000_517C;
         16:      return 32'h0000_28BE;
         17:      return 32'h0000_145F;
         18:      return 32'h0000_0A2F;
         19:      return 32'h0000_0517;
         20:      return 32'h0000_028B;
         21:      return 32'h0000_0145;
         22:      return 32'h0000_00A2;
         23:      return 32'h0000_0051;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/sine_wave_cordic_stage.sv
// One registered CORDIC rotation-mode iteration.
//   clk, reset (async, active low), ce (hold when low)
//   x_in/y_in/z_in   : vector and residual angle from the previous stage
//   x_out/y_out/z_out: vector rotated by -/+atan(2^-ITER), angle updated
module cordic_stage
   import sine_wave_pkg::*;
#(
   parameter int ITER        = 0,
   parameter int DATA_WIDTH  = 12,
   parameter int ANGLE_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ce,
   input  logic signed [DATA_WIDTH+1:0] x_in,
   input  logic signed [DATA_WIDTH+1:0] y_in,
   input  logic signed [ANGLE_WIDTH:0]  z_in,
   output logic signed [DATA_WIDTH+1:0] x_out,
   output logic signed [DATA_WIDTH+1:0] y_out,
   output logic signed [ANGLE_WIDTH:0]  z_out
);

   localparam int XW = DATA_WIDTH + 2;
   localparam int ZW = ANGLE_WIDTH + 1;
   localparam logic signed [ZW-1:0] ATAN_STEP = ZW'(atan_turn(ITER) >> (32 - ANGLE_WIDTH));

   logic signed [XW-1:0] x_shift;
   logic signed [XW-1:0] y_shift;

   assign x_shift = x_in >>> ITER;
   assign y_shift = y_in >>> ITER;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_out <= '0;
         y_out <= '0;
         z_out <= '0;
      end else if (ce) begin
         // z negative: rotate clockwise, otherwise counter-clockwise
         if (z_in[ZW-1]) begin
            x_out <= x_in + y_shift;
            y_out <= y_in - x_shift;
            z_out <= z_in + ATAN_STEP;
         end else begin
            x_out <= x_in - y_shift;
            y_out <= y_in + x_shift;
            z_out <= z_in - ATAN_STEP;
         end
      end
   end

endmodule

// File: rtl/sine_wave.sv
// Pipelined CORDIC sine/cosine generator driven by a phase accumulator.
//   clk      : single clock, rising edge
//   reset    : asynchronous, active low; clears phase, pipeline and outputs
//   ce       : clock enable; every register holds while low
//   ampl     : unsigned peak amplitude (0 .. 2^(DATA_WIDTH-1)-1)
//   step     : phase increment per enabled cycle (full turn = 2^ANGLE_WIDTH)
//   sin_wave : registered two's-complement ampl*sin(phase)
//   cos_wave : registered two's-complement ampl*cos(phase)
// Latency: DATA_WIDTH+2 enabled cycles (fold stage, DATA_WIDTH iterations,
// round/saturate output register).
module sine_wave
   import sine_wave_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int ANGLE_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   input  logic [DATA_WIDTH-1:0]  ampl,
   input  logic [ANGLE_WIDTH-1:0] step,
   output logic [DATA_WIDTH-1:0]  sin_wave,
   output logic [DATA_WIDTH-1:0]  cos_wave
);

   localparam int XW       = DATA_WIDTH + 2;
   localparam int ZW       = ANGLE_WIDTH + 1;
   localparam int PW       = XW + CORDIC_GAIN_BITS;
   localparam int X0_SHIFT = CORDIC_GAIN_BITS - XY_FRAC_BITS;

   localparam logic [PW-1:0]        GAIN_EXT   = PW'(CORDIC_GAIN);
   localparam logic signed [XW-1:0] ROUND_HALF = XW'(1 << (XY_FRAC_BITS - 1));
   localparam logic signed [XW-1:0] SAT_POS    = XW'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_NEG    = -SAT_POS;

   logic [ANGLE_WIDTH-1:0] phase;
   quadrant_t              quad;
   logic signed [XW-1:0]   x0_mag;

   logic signed [XW-1:0]   s0_x;
   logic signed [XW-1:0]   s0_y;
   logic signed [ZW-1:0]   s0_z;

   logic signed [XW-1:0]   x_chain [0:DATA_WIDTH];
   logic signed [XW-1:0]   y_chain [0:DATA_WIDTH];
   logic signed [ZW-1:0]   z_chain [0:DATA_WIDTH];

   logic signed [XW-1:0]   x_rnd;
   logic signed [XW-1:0]   y_rnd;
   logic signed [XW-1:0]   x_sat;
   logic signed [XW-1:0]   y_sat;

   assign quad = quadrant_t'(phase[ANGLE_WIDTH-1 -: 2]);

   // ampl*K expressed with XY_FRAC_BITS fractional bits
   assign x0_mag = XW'(((PW'(ampl)) * GAIN_EXT) >> X0_SHIFT);

   // Phase accumulator and quadrant pre-rotation. The residual angle is the
   // phase within its quarter turn, so z starts in [0, pi/2).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
         s0_x  <= '0;
         s0_y  <= '0;
         s0_z  <= '0;
      end else if (ce) begin
         phase <= phase + step;
         s0_z  <= ZW'(phase[ANGLE_WIDTH-3:0]);
         case (quad)
            QUAD_0: begin
               s0_x <= x0_mag;
               s0_y <= '0;
            end
            QUAD_90: begin
               s0_x <= '0;
               s0_y <= x0_mag;
            end
            QUAD_180: begin
               s0_x <= -x0_mag;
               s0_y <= '0;
            end
            QUAD_270: begin
               s0_x <= '0;
               s0_y <= -x0_mag;
            end
         endcase
      end
   end

   assign x_chain[0] = s0_x;
   assign y_chain[0] = s0_y;
   assign z_chain[0] = s0_z;

   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_iter
      cordic_stage #(
         .ITER        (g),
         .DATA_WIDTH  (DATA_WIDTH),
         .ANGLE_WIDTH (ANGLE_WIDTH)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .ce    (ce),
         .x_in  (x_chain[g]),
         .y_in  (y_chain[g]),
         .z_in  (z_chain[g]),
         .x_out (x_chain[g+1]),
         .y_out (y_chain[g+1]),
         .z_out (z_chain[g+1])
      );
   end

   // Drop the fractional bits with round-half-up, then clamp symmetrically.
   always_comb begin
      x_rnd = (x_chain[DATA_WIDTH] + ROUND_HALF) >>> XY_FRAC_BITS;
      y_rnd = (y_chain[DATA_WIDTH] + ROUND_HALF) >>> XY_FRAC_BITS;
      x_sat = x_rnd;
      y_sat = y_rnd;
      if (x_rnd > SAT_POS) begin
         x_sat = SAT_POS;
      end else if (x_rnd < SAT_NEG) begin
         x_sat = SAT_NEG;
      end
      if (y_rnd > SAT_POS) begin
         y_sat = SAT_POS;
      end else if (y_rnd < SAT_NEG) begin
         y_sat = SAT_NEG;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cos_wave <= '0;
         sin_wave <= '0;
      end else if (ce) begin
         cos_wave <= DATA_WIDTH'(x_sat);
         sin_wave <= DATA_WIDTH'(y_sat);
      end
   end

endmodule

// File: tb/tb_sine_wave.sv
// Bench for sine_wave: real-valued reference model with a per-cycle compare,
// plus literal expectations for the fixed-frequency scenarios.
module tb_sine_wave;

   localparam int  DW  = 12;
   localparam int  AW  = 16;
   localparam int  LAT = DW + 2;
   localparam int  TOL = 3;
   localparam real PI  = 3.14159265358979;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ce = 1'b0;
   logic [DW-1:0] ampl = '0;
   logic [AW-1:0] step = '0;
   logic [DW-1:0] sin_wave;
   logic [DW-1:0] cos_wave;

   int checks = 0;
   int errors = 0;

   sine_wave #(
      .DATA_WIDTH  (DW),
      .ANGLE_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .ampl     (ampl),
      .step     (step),
      .sin_wave (sin_wave),
      .cos_wave (cos_wave)
   );

   always #5 clk = ~clk;

   function automatic int sgn(input logic [DW-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int ref_val(input int a, input int unsigned ph, input bit want_sin);
      real ang;
      real v;
      ang = 2.0 * PI * real'(ph) / real'(1 << AW);
      v   = want_sin ? real'(a) * $sin(ang) : real'(a) * $cos(ang);
      return int'($floor(v + 0.5));
   endfunction

   task automatic check_near(input string name, input int act, input int exp_v, input int tol);
      checks++;
      if (act > exp_v + tol || act < exp_v - tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d at %0t", name, act, exp_v, tol, $time);
      end
   endtask

   // Reference model: every enabled edge captures (phase, ampl); that sample
   // reaches the outputs LAT enabled edges later. Before that, outputs are 0.
   int unsigned q_phase[$];
   int          q_ampl[$];
   int unsigned m_phase   = 0;
   bit          exp_valid = 1'b0;
   int unsigned exp_ph    = 0;
   int          exp_amp   = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_phase.delete();
         q_ampl.delete();
         m_phase   = 0;
         exp_valid = 1'b0;
      end else if (ce) begin
         q_phase.push_back(m_phase);
         q_ampl.push_back(int'(ampl));
         m_phase = (m_phase + int'(step)) % (1 << AW);
         if (q_phase.size() == LAT) begin
            exp_ph    = q_phase.pop_front();
            exp_amp   = q_ampl.pop_front();
            exp_valid = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!exp_valid) begin
         check_near("sin_idle", sgn(sin_wave), 0, 0);
         check_near("cos_idle", sgn(cos_wave), 0, 0);
      end else begin
         check_near("sin_model", sgn(sin_wave), ref_val(exp_amp, exp_ph, 1'b1), TOL);
         check_near("cos_model", sgn(cos_wave), ref_val(exp_amp, exp_ph, 1'b0), TOL);
      end
   end

   // Drivers act 1 time unit after the falling edge, clear of both compare
   // and the model's sampling edge.
   task automatic run(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic restart(input int a, input int unsigned s);
      reset = 1'b0;
      run(2);
      ampl  = DW'(a);
      step  = AW'(s);
      ce    = 1'b1;
      reset = 1'b1;
   endtask

   // Quarter-turn step: first sample is phase 0, then 90, 180, 270 degrees.
   task automatic quarter_seq(input string tag, input int a);
      int unit_s[4];
      int unit_c[4];
      unit_s = '{0, 1, 0, -1};
      unit_c = '{1, 0, -1, 0};
      for (int k = 0; k < 8; k++) begin
         check_near({tag, "_sin"}, sgn(sin_wave), a * unit_s[k % 4], TOL);
         check_near({tag, "_cos"}, sgn(cos_wave), a * unit_c[k % 4], TOL);
         run(1);
      end
   endtask

   initial begin
      int pk_max;
      int pk_min;

      #2;
      check_near("rst_sin", sgn(sin_wave), 0, 0);
      check_near("rst_cos", sgn(cos_wave), 0, 0);
      run(3);

      // quarter-turn, ampl 800
      restart(800, 16384);
      run(LAT - 1);
      check_near("latency_sin", sgn(sin_wave), 0, 0);
      check_near("latency_cos", sgn(cos_wave), 0, 0);
      run(1);
      quarter_seq("quarter800", 800);

      // constant phase 0
      restart(800, 0);
      run(LAT);
      for (int k = 0; k < 6; k++) begin
         check_near("dc_sin", sgn(sin_wave), 0, TOL);
         check_near("dc_cos", sgn(cos_wave), 800, TOL);
         run(1);
      end

      // step change mid-run, then peak amplitude over more than one period
      step = AW'(500);
      run(LAT + 2);
      pk_max = -100000;
      pk_min = 100000;
      for (int k = 0; k < 140; k++) begin
         if (sgn(sin_wave) > pk_max) pk_max = sgn(sin_wave);
         if (sgn(sin_wave) < pk_min) pk_min = sgn(sin_wave);
         run(1);
      end
      check_near("peak_pos", pk_max, 800, TOL);
      check_near("peak_neg", pk_min, -800, TOL);

      // clock enable held low mid-wave
      ce = 1'b0;
      run(10);
      ce = 1'b1;
      run(30);

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_near("async_rst_sin", sgn(sin_wave), 0, 0);
      check_near("async_rst_cos", sgn(cos_wave), 0, 0);
      run(2);
      ampl  = DW'(2047);
      step  = AW'(16384);
      reset = 1'b1;
      run(LAT);
      quarter_seq("quarter2047", 2047);

      // zero amplitude
      ampl = '0;
      step = AW'($urandom);
      run(LAT + 1);
      for (int k = 0; k < 10; k++) begin
         check_near("zero_sin", sgn(sin_wave), 0, 0);
         check_near("zero_cos", sgn(cos_wave), 0, 0);
         run(1);
      end

      // randomized enable, amplitude, step and occasional reset
      for (int k = 0; k < 1500; k++) begin
         ce    = ($urandom_range(0, 4) != 0);
         reset = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 15) == 0) ampl = DW'($urandom_range(0, 2047));
         if ($urandom_range(0, 15) == 0) step = AW'($urandom);
         run(1);
      end
      reset = 1'b1;
      ce    = 1'b1;
      run(LAT + 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
